// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan driver.
//   GLYPHS     - active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   HEX_BLANK  - all cathodes off (including the decimal point)
//   SEL_NONE   - all anodes off
//   digit_select() - active-low one-hot anode pattern for a digit index
package seg7_pkg;

    // Entry n is the glyph for hex value n; the highest entry is listed first.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    localparam logic [7:0] HEX_BLANK = 8'hFF;
    localparam logic [3:0] SEL_NONE  = 4'hF;

    function automatic logic [3:0] digit_select(input logic [1:0] index);
        return ~(4'b0001 << index);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational hex-to-seven-segment decoder.
//   value    [3:0] - hex digit to display
//   segments [6:0] - active-low cathodes {g,f,e,d,c,b,a}
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] segments
);

    always_comb begin
        segments = GLYPHS[value];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a 4-digit common-anode display.
// Each digit is lit for REFRESH_DIV clock cycles in turn (0,1,2,3,0,...).
//   CLK        - system clock, rising edge
//   RESET      - synchronous, active-high
//   ENABLE     - 1: scan and drive; 0: display dark, scan position frozen
//   IN0..IN3   - per-digit {dp_enable, hex[3:0]}; IN0 is the rightmost digit
//   SEG_SELECT - active-low anode enables, bit n drives digit n
//   HEX_OUT    - active-low cathodes {DP,g,f,e,d,c,b,a}
//   STROBE     - one-cycle pulse following each digit advance
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [4:0] IN0,
    input  logic [4:0] IN1,
    input  logic [4:0] IN2,
    input  logic [4:0] IN3,
    output logic [3:0] SEG_SELECT,
    output logic [7:0] HEX_OUT,
    output logic       STROBE
);

    // A divide-by-1 still needs a 1-bit counter that simply stays at zero.
    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);

    logic [PW-1:0] prescaler;
    logic [1:0]    index;
    logic          wrap;
    logic [4:0]    sel_digit;
    logic [6:0]    glyph;

    always_comb begin
        wrap = (prescaler == PRESC_MAX);
    end

    always_comb begin
        sel_digit = IN0;
        unique case (index)
            2'd0: sel_digit = IN0;
            2'd1: sel_digit = IN1;
            2'd2: sel_digit = IN2;
            2'd3: sel_digit = IN3;
            default: sel_digit = IN0;
        endcase
    end

    seg7_decoder u_decoder (
        .value    (sel_digit[3:0]),
        .segments (glyph)
    );

    // Outputs are registered from the pre-edge index, so they trail the index by one cycle;
    // STROBE therefore rises together with the new index, before the anodes move.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prescaler  <= '0;
            index      <= 2'd0;
            SEG_SELECT <= SEL_NONE;
            HEX_OUT    <= HEX_BLANK;
            STROBE     <= 1'b0;
        end else if (ENABLE) begin
            prescaler  <= wrap ? '0 : prescaler + PRESC_ONE;
            if (wrap) begin
                index <= index + 2'd1;
            end
            SEG_SELECT <= digit_select(index);
            HEX_OUT    <= {~sel_digit[4], glyph};
            STROBE     <= wrap;
        end else begin
            SEG_SELECT <= SEL_NONE;
            HEX_OUT    <= HEX_BLANK;
            STROBE     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: table-driven, scoreboard-checked bench for seg7_scan_driver.
// Main instance uses REFRESH_DIV=4; a second instance uses REFRESH_DIV=1.
module tb_seg7_scan_driver;

    logic       CLK = 1'b0;
    logic       RESET, ENABLE;
    logic [4:0] IN0, IN1, IN2, IN3;
    logic [3:0] SEG_SELECT;
    logic [7:0] HEX_OUT;
    logic       STROBE;

    logic       rst1;
    logic [3:0] seg1;
    logic [7:0] hex1;
    logic       stb1;

    int total = 0;
    int bad   = 0;
    int tag   = 0;

    always #5 CLK = ~CLK;

    seg7_scan_driver #(.REFRESH_DIV(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .IN0        (IN0),
        .IN1        (IN1),
        .IN2        (IN2),
        .IN3        (IN3),
        .SEG_SELECT (SEG_SELECT),
        .HEX_OUT    (HEX_OUT),
        .STROBE     (STROBE)
    );

    seg7_scan_driver #(.REFRESH_DIV(1)) dut1 (
        .CLK        (CLK),
        .RESET      (rst1),
        .ENABLE     (ENABLE),
        .IN0        (IN0),
        .IN1        (IN1),
        .IN2        (IN2),
        .IN3        (IN3),
        .SEG_SELECT (seg1),
        .HEX_OUT    (hex1),
        .STROBE     (stb1)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [4:0] in0, in1, in2, in3;
        logic [3:0] seg;
        logic [7:0] hex;
        logic       stb;
    } vec_t;

    typedef struct {
        logic [3:0] seg;
        logic [7:0] hex;
        logic       stb;
        int         tag;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int t, input logic [7:0] got,
                       input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, t, got, want);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic en, input logic [4:0] i0,
                                input logic [4:0] i1, input logic [4:0] i2,
                                input logic [4:0] i3, input logic [3:0] seg,
                                input logic [7:0] hex, input logic stb);
        vec_t v;
        v.rst = rst; v.en = en;
        v.in0 = i0; v.in1 = i1; v.in2 = i2; v.in3 = i3;
        v.seg = seg; v.hex = hex; v.stb = stb;
        return v;
    endfunction

    // Drive one cycle; the expectation for the following edge goes to the scoreboard.
    task automatic cyc(input vec_t v);
        exp_t e;
        RESET = v.rst; ENABLE = v.en;
        IN0 = v.in0; IN1 = v.in1; IN2 = v.in2; IN3 = v.in3;
        @(posedge CLK);
        e.seg = v.seg; e.hex = v.hex; e.stb = v.stb; e.tag = tag;
        sb.push_back(e);
        tag++;
        #1;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation on the falling edge.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("seg_select", e.tag, {4'h0, SEG_SELECT}, {4'h0, e.seg});
            chk("hex_out",    e.tag, HEX_OUT, e.hex);
            chk("strobe",     e.tag, {7'h0, STROBE}, {7'h0, e.stb});
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl[28];
        logic [3:0] seg_seq[7];
        logic [7:0] hex_seq[7];
        logic [3:0] rot_seg[4];
        logic [7:0] rot_hex[4];
        logic [4:0] i2;
        int         d;

        seg_seq = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB};
        hex_seq = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'hC0, 8'hF9, 8'h00};
        rot_seg = '{4'hE, 4'hD, 4'hB, 4'h7};
        rot_hex = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};

        // Normal scan: each digit dwells 4 cycles; IN2 gains DP and value 8 after cycle 20.
        for (int n = 1; n <= 28; n++) begin
            d  = (n - 1) / 4;
            i2 = (n > 20) ? 5'h18 : 5'd2;
            tbl[n-1] = mk(1'b0, 1'b1, 5'd0, 5'd1, i2, 5'd3, seg_seq[d], hex_seq[d],
                          (n % 4) == 0);
        end

        rst1 = 1'b1;
        RESET = 1'b1; ENABLE = 1'b1;
        IN0 = 5'd0; IN1 = 5'd1; IN2 = 5'd2; IN3 = 5'd3;

        // Reset for two cycles: dark display, no strobe.
        repeat (2) cyc(mk(1'b1, 1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 4'hF, 8'hFF, 1'b0));

        for (int i = 0; i < 28; i++) cyc(tbl[i]);

        // Digit 3, digit 0, then two cycles into digit 1.
        for (int k = 1; k <= 4; k++)
            cyc(mk(1'b0, 1'b1, 5'd0, 5'd1, 5'h18, 5'd3, 4'h7, 8'hB0, k == 4));
        for (int k = 1; k <= 4; k++)
            cyc(mk(1'b0, 1'b1, 5'd0, 5'd1, 5'h18, 5'd3, 4'hE, 8'hC0, k == 4));
        repeat (2) cyc(mk(1'b0, 1'b1, 5'd0, 5'd1, 5'h18, 5'd3, 4'hD, 8'hF9, 1'b0));

        // Freeze mid-digit-1 for 10 cycles.
        repeat (10) cyc(mk(1'b0, 1'b0, 5'd0, 5'd1, 5'h18, 5'd3, 4'hF, 8'hFF, 1'b0));

        // Resume: only the remaining two cycles of digit 1.
        cyc(mk(1'b0, 1'b1, 5'd0, 5'd1, 5'h18, 5'd3, 4'hD, 8'hF9, 1'b0));
        cyc(mk(1'b0, 1'b1, 5'd0, 5'd1, 5'h18, 5'd3, 4'hD, 8'hF9, 1'b1));
        for (int k = 1; k <= 4; k++)
            cyc(mk(1'b0, 1'b1, 5'd0, 5'd1, 5'h18, 5'd3, 4'hB, 8'h00, k == 4));
        cyc(mk(1'b0, 1'b1, 5'd0, 5'd1, 5'h18, 5'd3, 4'h7, 8'hB0, 1'b0));

        // Reset while digit 3 is active, then full dwell on digit 0 with IN0 0 -> F.
        cyc(mk(1'b1, 1'b1, 5'd0, 5'd1, 5'h18, 5'd3, 4'hF, 8'hFF, 1'b0));
        repeat (2) cyc(mk(1'b0, 1'b1, 5'd0, 5'd1, 5'h18, 5'd3, 4'hE, 8'hC0, 1'b0));
        cyc(mk(1'b0, 1'b1, 5'h0F, 5'd1, 5'h18, 5'd3, 4'hE, 8'h8E, 1'b0));
        cyc(mk(1'b0, 1'b1, 5'h0F, 5'd1, 5'h18, 5'd3, 4'hE, 8'h8E, 1'b1));
        cyc(mk(1'b0, 1'b1, 5'h0F, 5'd1, 5'h18, 5'd3, 4'hD, 8'hF9, 1'b0));

        @(negedge CLK);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end

        // REFRESH_DIV=1 instance: held in reset until now.
        IN0 = 5'd0; IN1 = 5'd1; IN2 = 5'd2; IN3 = 5'd3; ENABLE = 1'b1;
        chk("div1_reset_seg", 0, {4'h0, seg1}, 8'h0F);
        chk("div1_reset_hex", 0, hex1, 8'hFF);
        chk("div1_reset_stb", 0, {7'h0, stb1}, 8'h00);
        rst1 = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(posedge CLK);
            #1;
            chk("div1_seg", j, {4'h0, seg1}, {4'h0, rot_seg[(j-1) % 4]});
            chk("div1_hex", j, hex1, rot_hex[(j-1) % 4]);
            chk("div1_stb", j, {7'h0, stb1}, 8'h01);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHALL set the number of CLK cycles each digit is displayed (1 kHz digit rate at 100 MHz).
REQ-002 Port CLK  input  1  system clock; one clock; all state SHALL be updated on its rising edge.
REQ-003 Port RESET  input  1  reset, synchronous and active-high.
REQ-004 Port ENABLE  input  1  high = scan and drive display; low = display dark, scan frozen.
REQ-005 Port IN0  input  5  digit 0 (rightmost): [3:0] hex value, [4] decimal-point enable.
REQ-006 Port IN1  input  5  digit 1, same encoding.
REQ-007 Port IN2  input  5  digit 2, same encoding.
REQ-008 Port IN3  input  5  digit 3 (leftmost), same encoding.
REQ-009 Port SEG_SELECT  output  4  anode enables, active-low, one-hot-low; bit n drives digit n.
REQ-010 Port HEX_OUT  output  8  cathodes, active-low, order {DP,g,f,e,d,c,b,a}.
REQ-011 Port STROBE  output  1  single-cycle pulse marking each digit advance.

Function
REQ-012 Prescaler SHALL count 0..REFRESH_DIV-1 while ENABLE=1, wrapping to 0 after REFRESH_DIV-1.
REQ-013 Digit index (2 bits) SHALL increment modulo 4 on the cycle the prescaler wraps; 3 -> 0 wrap is normal.
REQ-014 STROBE SHALL be 1 for exactly the one cycle after each digit-index increment, else 0.
REQ-015 Outputs SHALL be registered, one-cycle latency: SEG_SELECT/HEX_OUT at edge k+1 reflect digit index and selected INn at edge k.
REQ-016 SEG_SELECT SHALL be ~(4'b0001 << index) when ENABLE=1; never more than one bit low.
REQ-017 HEX_OUT[6:0] SHALL be the active-low hex glyph of INn[3:0] (0->7'b1000000, 8->7'b0000000, F->7'b0001110); HEX_OUT[7] SHALL be ~INn[4].
REQ-018 Changes of INn SHALL appear on HEX_OUT one cycle later if digit n is currently selected; no other effect.
REQ-019 ENABLE=0: prescaler and index SHALL hold; next cycle SEG_SELECT=4'b1111, HEX_OUT=8'hFF, STROBE=0.
REQ-020 ENABLE 0->1: scanning SHALL resume from the held prescaler/index values; outputs valid one cycle later.
REQ-021 REFRESH_DIV=1 SHALL advance the index every cycle; REFRESH_DIV<1 is illegal.
REQ-022 Prescaler width SHALL be $clog2(REFRESH_DIV) bits, minimum 1; no overflow beyond REFRESH_DIV-1.

Reset
REQ-023 RESET=1 at a rising edge SHALL set prescaler=0, index=0, SEG_SELECT=4'b1111, HEX_OUT=8'hFF, STROBE=0, overriding ENABLE.
REQ-024 RESET asserted mid-scan SHALL abort immediately; first edge after release with ENABLE=1 SHALL drive SEG_SELECT=4'b1110 showing IN0.

Structure
REQ-025 Active-low glyph constants for 0..F and blank value 8'hFF SHALL reside in shared package seg7_pkg.
REQ-026 Hex-to-segment mapping SHALL be one combinational sub-module, seg7_decoder (4-bit in, 7-bit active-low out).
REQ-027 Digit selection from IN0..IN3 SHALL reuse the team's existing 5-bit 2:1 mux block in a two-level tree, or an equivalent case select.

Verification (REFRESH_DIV=4 on bench)
REQ-028 RESET 2 cycles, ENABLE=1, IN0..IN3=0,1,2,3 -> SEG_SELECT sequence 1110,1101,1011,0111,1110 each held 4 cycles; HEX_OUT 8'hC0,8'hF9,8'hA4,8'hB0.
REQ-029 IN2=5'b1_1000 -> during SEG_SELECT=1011, HEX_OUT=8'h00; STROBE pulses once per 4 cycles, 1 cycle wide.
REQ-030 ENABLE low for 10 cycles mid-digit-1 -> SEG_SELECT=1111, HEX_OUT=FF; on re-enable digit 1 resumes for remaining prescaler count.
REQ-031 RESET pulsed while index=3 -> next cycle outputs 1111/FF; after release digit 0 shown first with full 4-cycle dwell.
REQ-032 IN0 changed from 0 to F while digit 0 active -> HEX_OUT 8'hC0 -> 8'h8E one cycle later; SEG_SELECT unchanged.
REQ-033 REFRESH_DIV=1 build -> SEG_SELECT rotates every cycle, STROBE constantly 1 after first advance.
